// File: rtl/llr_frame_buffer_if.sv
// Bus bundle for the LLR frame buffer: a symbol input stream from the soft slicer
// and a framed, flow-controlled output stream toward the RS decoder.
interface llr_frame_buffer_if #(
    parameter int LLR_RESOLUTION = 5,
    parameter int MAX_ERASURES   = 8
);
    localparam int CNT_W = $clog2(MAX_ERASURES + 1);

    logic [1:0]                symbol_in;
    logic [LLR_RESOLUTION-1:0] llr_in;
    logic                      llr_sign_in;
    logic                      symbol_in_valid;
    logic                      out_ready;

    logic [1:0]                symbol_out;
    logic                      llr_sign_out;
    logic                      erasure_out;
    logic                      out_valid;
    logic                      sof;
    logic                      eof;
    logic [CNT_W-1:0]          frame_erasures;
    logic                      overflow;
    logic [15:0]               drop_count;

    modport master (
        output symbol_in, llr_in, llr_sign_in, symbol_in_valid, out_ready,
        input  symbol_out, llr_sign_out, erasure_out, out_valid, sof, eof,
               frame_erasures, overflow, drop_count
    );

    modport slave (
        input  symbol_in, llr_in, llr_sign_in, symbol_in_valid, out_ready,
        output symbol_out, llr_sign_out, erasure_out, out_valid, sof, eof,
               frame_erasures, overflow, drop_count
    );
endinterface

// File: rtl/llr_frame_buffer.sv
// Ping-pong frame buffer between the PAM-4 soft slicer and the RS decoder; flags
// low-reliability symbols as erasures (capped per frame) and drops input when both banks are full.
module llr_frame_buffer #(
    parameter int LLR_RESOLUTION    = 5,
    parameter int FRAME_LEN         = 32,
    parameter int ERASURE_THRESHOLD = 4,
    parameter int MAX_ERASURES      = 8
) (
    input logic clk,
    input logic rstn,
    llr_frame_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(FRAME_LEN);
    localparam int CNT_W = $clog2(MAX_ERASURES + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(MAX_ERASURES);
    localparam logic [31:0]      THR      = 32'(ERASURE_THRESHOLD);

    // Entry layout: {symbol[1:0], sign, erasure}; address is {bank, ptr}.
    logic [3:0]       mem [2*FRAME_LEN];

    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] lat_cnt [2];
    logic             overflow;
    logic [15:0]      drop_count;

    logic             accept;
    logic             drop;
    logic             candidate;
    logic             ers_bit;
    logic             wr_last;
    logic             out_valid;
    logic             xfer;
    logic             rd_last;
    logic [3:0]       rd_word;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;

    // Acceptance looks at the full flag as registered, so a bank freed by an
    // eof transfer only becomes writable on the following cycle.
    assign accept    = bus.symbol_in_valid & ~full[wr_bank];
    assign drop      = bus.symbol_in_valid &  full[wr_bank];
    assign candidate = 32'(bus.llr_in) < THR;
    assign ers_bit   = candidate && (run_cnt < CNT_CAP);
    assign wr_last   = (wr_ptr == LAST_PTR);

    assign out_valid = full[rd_bank];
    assign xfer      = out_valid & bus.out_ready;
    assign rd_last   = (rd_ptr == LAST_PTR);
    assign rd_word   = mem[{rd_bank, rd_ptr}];

    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (accept && wr_last) full_set[wr_bank] = 1'b1;
        if (xfer && rd_last)   full_clr[rd_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[{wr_bank, wr_ptr}] <= {bus.symbol_in, bus.llr_sign_in, ers_bit};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            wr_ptr  <= '0;
            run_cnt <= '0;
            lat_cnt[0] <= '0;
            lat_cnt[1] <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_last) begin
                    lat_cnt[wr_bank] <= run_cnt + CNT_W'(ers_bit);
                    run_cnt          <= '0;
                    wr_bank          <= ~wr_bank;
                end else if (ers_bit) begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_bank <= 1'b0;
            rd_ptr  <= '0;
        end else if (xfer) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_last) rd_bank <= ~rd_bank;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
        end
    end

    // Fields are forced to zero whenever no frame is presented, so reset blanks them at once.
    assign bus.out_valid      = out_valid;
    assign bus.symbol_out     = out_valid ? rd_word[3:2] : 2'b00;
    assign bus.llr_sign_out   = out_valid & rd_word[1];
    assign bus.erasure_out    = out_valid & rd_word[0];
    assign bus.sof            = out_valid & (rd_ptr == '0);
    assign bus.eof            = out_valid & rd_last;
    assign bus.frame_erasures = out_valid ? lat_cnt[rd_bank] : '0;
    assign bus.overflow       = overflow;
    assign bus.drop_count     = drop_count;
endmodule

// File: doc/llr_frame_buffer.md
LLR_FRAME_BUFFER -- requirements
Module: llr_frame_buffer

Interface
REQ-001 Parameter LLR_RESOLUTION, default 5, soft-slicer LLR magnitude width in bits.
REQ-002 Parameter FRAME_LEN, default 32, symbols per frame (power of 2, >=4).
REQ-003 Parameter ERASURE_THRESHOLD, default 4, LLR magnitude strictly below which a symbol is an erasure candidate.
REQ-004 Parameter MAX_ERASURES, default 8, per-frame erasure cap (1..FRAME_LEN).
REQ-005 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock.
REQ-006 rstn input 1, asynchronous active-low reset.
REQ-007 symbol_in input 2, Gray-coded PAM-4 hard decision from the soft slicer.
REQ-008 llr_in input LLR_RESOLUTION, unsigned reliability magnitude.
REQ-009 llr_sign_in input 1, LLR sign, stored alongside the symbol.
REQ-010 symbol_in_valid input 1, one symbol per asserted cycle; no input backpressure.
REQ-011 out_ready input 1, downstream (RS decoder) accepts current output word.
REQ-012 symbol_out output 2; llr_sign_out output 1; erasure_out output 1, symbol flagged as erasure.
REQ-013 out_valid output 1; sof output 1, first symbol of frame; eof output 1, last symbol of frame.
REQ-014 frame_erasures output clog2(MAX_ERASURES+1), erasure count of the frame being output, stable for the whole frame.
REQ-015 overflow output 1, sticky drop flag; drop_count output 16, saturating dropped-symbol count.

Function
REQ-016 Storage SHALL be two banks of FRAME_LEN entries {symbol, sign, erasure}, used ping-pong via wr_bank and rd_bank pointers plus per-bank full flags.
REQ-017 A symbol SHALL be accepted when symbol_in_valid=1 and the full flag of wr_bank is 0 at the start of the cycle, and written at wr_ptr.
REQ-018 erasure bit SHALL be 1 iff llr_in < ERASURE_THRESHOLD and the current frame's running erasure count < MAX_ERASURES; count increments only when the bit is set.
REQ-019 Erasure candidates beyond the cap SHALL be written with erasure=0; cap is first-come in arrival order.
REQ-020 On accepting the symbol at wr_ptr=FRAME_LEN-1: set that bank full, latch its erasure count, clear running count and wr_ptr to 0, toggle wr_bank.
REQ-021 wr_ptr SHALL wrap from FRAME_LEN-1 to 0 with no gap cycle; back-to-back frames are accepted at full rate while the other bank is free.
REQ-022 out_valid SHALL equal the full flag of rd_bank; output fields SHALL come from entry rd_ptr of rd_bank (first-word fall-through).
REQ-023 Earliest out_valid for a frame SHALL be the cycle after the edge accepting its last symbol (latency 1 cycle).
REQ-024 sof SHALL be 1 when out_valid and rd_ptr=0; eof when out_valid and rd_ptr=FRAME_LEN-1.
REQ-025 Transfer occurs on out_valid & out_ready; rd_ptr increments; on eof transfer clear the bank's full flag, rd_ptr to 0, toggle rd_bank.
REQ-026 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 A bank freed by an eof transfer SHALL be writable from the following cycle, not the same cycle.
REQ-028 symbol_in_valid=1 with wr_bank full SHALL drop the symbol, set overflow, increment drop_count (saturate at 65535); wr_ptr and erasure count unchanged.
REQ-029 overflow and drop_count SHALL clear only on reset.

Reset
REQ-030 Asserting rstn=0 SHALL immediately clear: full flags, pointers, banks selects to 0, running and latched erasure counts, overflow, drop_count; out_valid, sof, eof, erasure_out, symbol_out, llr_sign_out = 0.
REQ-031 Reset mid-frame SHALL discard partial and complete frames; memory contents need not be cleared.
REQ-032 First symbol after rstn deassertion SHALL be written to bank 0, entry 0.

Verification
REQ-033 FRAME_LEN=32, 32 valid symbols all llr_in=31, out_ready=1 -> out_valid cycle after last write, 32 outputs in order, sof on 1st, eof on 32nd, erasure_out all 0, frame_erasures=0.
REQ-034 Frame with llr_in=0 on symbols 0..11, MAX_ERASURES=8 -> erasure_out=1 on symbols 0..7 only, frame_erasures=8.
REQ-035 out_ready=0, 3 full frames streamed continuously -> frames 1,2 stored, all 32 symbols of frame 3 dropped, overflow=1, drop_count=32; frame 1 then output intact after out_ready=1.
REQ-036 Continuous input, out_ready=1 -> no drops over 100 frames, output data equals input data, bank toggles without gaps.
REQ-037 rstn pulsed low at input symbol 17 with a full frame pending -> outputs 0 immediately, next frame output starts from post-reset symbol 0.
REQ-038 out_ready toggled randomly -> outputs stable while stalled, no duplicated or lost symbols.
